// File: rtl/fetch_sequencer.sv
// Two-phase fetch/execute controller: sequences PC strobes and the fetch-register
// enable, resolves two-byte jumps, issues execute pulses and counts retired instructions.
module fetch_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic              resume,
  input  logic [3:0]        instr,
  input  logic [3:0]        oprnd,
  input  logic [7:0]        program_byte,
  input  logic              c_flag,
  input  logic              z_flag,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_target,
  output logic              fetch_en,
  output logic              exec_strobe,
  output logic              phase,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] OP_JC   = 4'b0000;
  localparam logic [3:0] OP_JNC  = 4'b0001;
  localparam logic [3:0] OP_JZ   = 4'b1000;
  localparam logic [3:0] OP_JNZ  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             active;

  // Reset in the same cycle suppresses every strobe, even mid-EXEC.
  assign active = ~hold & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    retired_d   = retired_q;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    fetch_en    = 1'b0;
    exec_strobe = 1'b0;
    if (active) begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_FETCH;
        end
        S_FETCH: begin
          fetch_en = 1'b1;
          pc_inc   = 1'b1;
          state_d  = S_EXEC;
        end
        S_EXEC: begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
          // Untaken conditional jumps step over their address byte.
          case (instr)
            OP_JMP: pc_load = 1'b1;
            OP_JZ: begin
              pc_load = z_flag;
              pc_inc  = ~z_flag;
            end
            OP_JNZ: begin
              pc_load = ~z_flag;
              pc_inc  = z_flag;
            end
            OP_JC: begin
              pc_load = c_flag;
              pc_inc  = ~c_flag;
            end
            OP_JNC: begin
              pc_load = ~c_flag;
              pc_inc  = c_flag;
            end
            OP_HALT: state_d = S_HALTED;
            default: exec_strobe = 1'b1;
          endcase
        end
        S_HALTED: begin
          if (resume) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign pc_target = ADDR_W'({oprnd, program_byte});
  assign phase     = (state_q == S_EXEC);
  assign halted    = (state_q == S_HALTED);
  assign retired   = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a small PC/ROM/fetch-register model closes the loop
// around the controller; expected values are hand-computed per scenario.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0, start = 1'b0, hold = 1'b0, resume = 1'b0;
  logic        c_flag = 1'b0, z_flag = 1'b0;
  logic [3:0]  instr, oprnd;
  logic [7:0]  program_byte;
  logic        pc_inc, pc_load, fetch_en, exec_strobe, phase, halted;
  logic [11:0] pc_target;
  logic [15:0] retired;
  logic        w_pc_inc, w_pc_load, w_fetch_en, w_exec_strobe, w_phase, w_halted;
  logic [11:0] w_pc_target;
  logic [3:0]  retired_w;

  logic [7:0]  rom [4096];
  logic [11:0] pc;
  logic [7:0]  fr;
  logic [5:0]  sv;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(12), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .resume(resume),
    .instr(instr), .oprnd(oprnd), .program_byte(program_byte),
    .c_flag(c_flag), .z_flag(z_flag),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target), .fetch_en(fetch_en),
    .exec_strobe(exec_strobe), .phase(phase), .halted(halted), .retired(retired)
  );

  // Narrow-counter twin driven by identical inputs, used to reach the counter wrap quickly.
  fetch_sequencer #(.ADDR_W(12), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .resume(resume),
    .instr(instr), .oprnd(oprnd), .program_byte(program_byte),
    .c_flag(c_flag), .z_flag(z_flag),
    .pc_inc(w_pc_inc), .pc_load(w_pc_load), .pc_target(w_pc_target), .fetch_en(w_fetch_en),
    .exec_strobe(w_exec_strobe), .phase(w_phase), .halted(w_halted), .retired(retired_w)
  );

  assign instr        = fr[7:4];
  assign oprnd        = fr[3:0];
  assign program_byte = rom[pc];
  assign sv           = {fetch_en, pc_inc, pc_load, exec_strobe, phase, halted};

  always @(posedge clk) begin
    if (reset) begin
      pc <= 12'h000;
      fr <= 8'h00;
    end else begin
      if (pc_load)     pc <= pc_target;
      else if (pc_inc) pc <= pc + 12'h001;
      if (fetch_en)    fr <= rom[pc];
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
    #1;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 4096; a++) rom[a] = 8'h42;
  endtask

  task automatic test_reset();
    clear_rom();
    do_reset();
    checks++; if (sv !== 6'b000000) begin failures++; $display("FAIL reset_sv got=%b exp=%b", sv, 6'b000000); end
    checks++; if (retired !== 16'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    cyc();
    checks++; if (sv !== 6'b000000) begin failures++; $display("FAIL idle_no_start got=%b exp=%b", sv, 6'b000000); end
  endtask

  task automatic test_basic();
    clear_rom();
    rom[0] = 8'h42; rom[1] = 8'h53;
    do_reset();
    start_run();
    checks++; if (sv !== 6'b110000) begin failures++; $display("FAIL basic_fetch1 got=%b exp=%b", sv, 6'b110000); end
    cyc();
    checks++; if (sv !== 6'b000110) begin failures++; $display("FAIL basic_exec1 got=%b exp=%b", sv, 6'b000110); end
    cyc();
    checks++; if (sv !== 6'b110000) begin failures++; $display("FAIL basic_fetch2 got=%b exp=%b", sv, 6'b110000); end
    cyc();
    checks++; if (sv !== 6'b000110 || fr !== 8'h53) begin failures++; $display("FAIL basic_exec2 got=%b/%h exp=%b/53", sv, fr, 6'b000110); end
    cyc();
    checks++; if (retired !== 16'd2) begin failures++; $display("FAIL basic_retired got=%0d exp=2", retired); end
  endtask

  task automatic test_jmp();
    clear_rom();
    rom[0] = 8'hB3; rom[1] = 8'h7A; rom[12'h37A] = 8'h5E;
    do_reset();
    start_run();
    cyc();
    checks++; if (sv !== 6'b001010) begin failures++; $display("FAIL jmp_exec got=%b exp=%b", sv, 6'b001010); end
    checks++; if (pc_target !== 12'h37A) begin failures++; $display("FAIL jmp_target got=%h exp=37a", pc_target); end
    cyc();
    checks++; if (pc !== 12'h37A || sv !== 6'b110000) begin failures++; $display("FAIL jmp_next_fetch got=%h/%b exp=37a/%b", pc, sv, 6'b110000); end
    cyc();
    checks++; if (fr !== 8'h5E || sv !== 6'b000110) begin failures++; $display("FAIL jmp_landed got=%h/%b exp=5e/%b", fr, sv, 6'b000110); end
  endtask

  task automatic test_cond();
    logic [3:0] op;
    logic       c, z, tk;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin op = 4'hB; c = 1'b0; z = 1'b0; tk = 1'b1; end
        1: begin op = 4'h8; c = 1'b1; z = 1'b0; tk = 1'b0; end
        2: begin op = 4'h8; c = 1'b0; z = 1'b1; tk = 1'b1; end
        3: begin op = 4'h9; c = 1'b1; z = 1'b0; tk = 1'b1; end
        4: begin op = 4'h9; c = 1'b0; z = 1'b1; tk = 1'b0; end
        5: begin op = 4'h0; c = 1'b1; z = 1'b0; tk = 1'b1; end
        6: begin op = 4'h0; c = 1'b0; z = 1'b1; tk = 1'b0; end
        7: begin op = 4'h1; c = 1'b1; z = 1'b0; tk = 1'b0; end
        default: begin op = 4'h1; c = 1'b0; z = 1'b1; tk = 1'b1; end
      endcase
      clear_rom();
      rom[0] = {op, 4'h5}; rom[1] = 8'hC3;
      c_flag = c; z_flag = z;
      do_reset();
      start_run();
      cyc();
      checks++;
      if (sv !== (tk ? 6'b001010 : 6'b010010)) begin
        failures++; $display("FAIL cond%0d_exec got=%b exp=%b", i, sv, tk ? 6'b001010 : 6'b010010);
      end
      cyc();
      checks++;
      if (pc !== (tk ? 12'h5C3 : 12'h002)) begin
        failures++; $display("FAIL cond%0d_pc got=%h exp=%h", i, pc, tk ? 12'h5C3 : 12'h002);
      end
    end
    c_flag = 1'b0; z_flag = 1'b0;
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'h42; rom[1] = 8'hF0; rom[2] = 8'h53;
    do_reset();
    start_run();
    cyc(); cyc(); cyc();
    checks++; if (sv !== 6'b000010) begin failures++; $display("FAIL halt_exec got=%b exp=%b", sv, 6'b000010); end
    cyc();
    for (int k = 0; k < 10; k++) begin
      checks++; if (sv !== 6'b000001) begin failures++; $display("FAIL halted_c%0d got=%b exp=%b", k, sv, 6'b000001); end
      cyc();
    end
    checks++; if (retired !== 16'd2 || pc !== 12'h002) begin failures++; $display("FAIL halt_retired_pc got=%0d/%h exp=2/002", retired, pc); end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    #1;
    checks++; if (sv !== 6'b110000 || pc !== 12'h002) begin failures++; $display("FAIL resume_fetch got=%b/%h exp=%b/002", sv, pc, 6'b110000); end
    cyc();
    checks++; if (fr !== 8'h53 || sv !== 6'b000110) begin failures++; $display("FAIL resume_exec got=%h/%b exp=53/%b", fr, sv, 6'b000110); end
  endtask

  task automatic test_hold();
    clear_rom();
    rom[0] = 8'h42; rom[1] = 8'h53;
    do_reset();
    start_run();
    hold = 1'b1;
    #1;
    checks++; if (sv !== 6'b000000) begin failures++; $display("FAIL hold_fetch got=%b exp=%b", sv, 6'b000000); end
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++; if (sv !== 6'b000000 || pc !== 12'h000) begin failures++; $display("FAIL hold_frozen%0d got=%b/%h exp=%b/000", k, sv, pc, 6'b000000); end
    end
    hold = 1'b0;
    #1;
    checks++; if (sv !== 6'b110000) begin failures++; $display("FAIL hold_release got=%b exp=%b", sv, 6'b110000); end
    cyc();
    checks++; if (sv !== 6'b000110 || pc !== 12'h001 || fr !== 8'h42) begin failures++; $display("FAIL hold_single_fetch got=%b/%h/%h exp=%b/001/42", sv, pc, fr, 6'b000110); end
    hold = 1'b1;
    #1;
    checks++; if (sv !== 6'b000010) begin failures++; $display("FAIL hold_exec got=%b exp=%b", sv, 6'b000010); end
    cyc();
    checks++; if (retired !== 16'd0) begin failures++; $display("FAIL hold_retired got=%0d exp=0", retired); end
    hold = 1'b0;
    #1;
    checks++; if (sv !== 6'b000110) begin failures++; $display("FAIL hold_exec_release got=%b exp=%b", sv, 6'b000110); end
    cyc();
    checks++; if (retired !== 16'd1 || sv !== 6'b110000) begin failures++; $display("FAIL hold_after got=%0d/%b exp=1/%b", retired, sv, 6'b110000); end
  endtask

  task automatic test_reset_exec();
    clear_rom();
    rom[0] = 8'h42; rom[1] = 8'hB3; rom[2] = 8'h7A;
    do_reset();
    start_run();
    cyc(); cyc(); cyc();
    reset = 1'b1;
    #1;
    checks++; if (sv !== 6'b000010) begin failures++; $display("FAIL rst_exec_strobes got=%b exp=%b", sv, 6'b000010); end
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (sv !== 6'b000000 || retired !== 16'd0 || pc !== 12'h000) begin failures++; $display("FAIL rst_exec_idle got=%b/%0d/%h exp=%b/0/000", sv, retired, pc, 6'b000000); end
  endtask

  task automatic test_pc_wrap();
    clear_rom();
    rom[0] = 8'hBF; rom[1] = 8'hFF; rom[12'hFFF] = 8'hB1; rom[12'h1BF] = 8'h53;
    do_reset();
    start_run();
    cyc(); cyc();
    checks++; if (pc !== 12'hFFF) begin failures++; $display("FAIL wrap_fetch_pc got=%h exp=fff", pc); end
    cyc();
    checks++; if (sv !== 6'b001010 || pc_target !== 12'h1BF) begin failures++; $display("FAIL wrap_jmp got=%b/%h exp=%b/1bf", sv, pc_target, 6'b001010); end
    cyc(); cyc();
    checks++; if (fr !== 8'h53) begin failures++; $display("FAIL wrap_landed got=%h exp=53", fr); end
  endtask

  task automatic test_retired_wrap();
    clear_rom();
    do_reset();
    start_run();
    for (int k = 0; k < 15; k++) begin cyc(); cyc(); end
    checks++; if (retired_w !== 4'd15 || retired !== 16'd15) begin failures++; $display("FAIL cnt_15 got=%0d/%0d exp=15/15", retired_w, retired); end
    cyc(); cyc();
    checks++; if (retired_w !== 4'd0 || retired !== 16'd16) begin failures++; $display("FAIL cnt_wrap got=%0d/%0d exp=0/16", retired_w, retired); end
    for (int k = 0; k < 4; k++) begin cyc(); cyc(); end
    checks++; if (retired_w !== 4'd4 || retired !== 16'd20) begin failures++; $display("FAIL cnt_after got=%0d/%0d exp=4/20", retired_w, retired); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_jmp();
    test_cond();
    test_halt();
    test_hold();
    test_reset_exec();
    test_pc_wrap();
    test_retired_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Two-phase fetch/execute controller for the program-counter / program-ROM / fetch-register datapath.
- Drives the PC increment and load strobes and the fetch-register enable.
- Decodes the 4-bit instr field to resolve two-byte conditional and unconditional jumps.
- Issues a one-cycle execute strobe to downstream ALU/IO logic, supports halt and hold, and counts retired instructions.

Parameters:
- ADDR_W, 12, program-counter width; jump target is {oprnd, program_byte}, so ADDR_W must equal 4 + 8.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  leaves IDLE; ignored in all other states.
- hold  in  1  freezes the FSM; all strobes forced to 0 while high.
- resume  in  1  leaves HALTED.
- instr  in  4  fetch-register upper nibble (opcode).
- oprnd  in  4  fetch-register lower nibble.
- program_byte  in  8  combinational ROM output at the current PC.
- c_flag  in  1  carry flag from the ALU.
- z_flag  in  1  zero flag from the ALU.
- pc_inc  out  1  PC enable (increment).
- pc_load  out  1  PC load strobe.
- pc_target  out  ADDR_W  PC load value.
- fetch_en  out  1  fetch-register enable.
- exec_strobe  out  1  one-cycle execute pulse for non-jump opcodes.
- phase  out  1  0 = fetch, 1 = execute.
- halted  out  1  high in HALTED.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE, FETCH, EXEC, HALTED. Reset (sync) -> IDLE; retired=0.
- All strobes are 0 in IDLE and HALTED, and whenever hold=1.
- phase=1 only in EXEC; halted=1 only in HALTED.
- IDLE: start=1 -> FETCH.
- FETCH, hold=0:
  - fetch_en=1, pc_inc=1.
  - The same edge captures ROM[PC] into instr/oprnd and advances PC, so in EXEC program_byte = byte after the opcode.
  - Next state EXEC.
- EXEC, hold=0, decode on instr:
  - 4'b1011 JMP: pc_load=1.
  - 4'b1000 JZ: pc_load=z_flag, else pc_inc=1.
  - 4'b1001 JNZ: pc_load=~z_flag, else pc_inc=1.
  - 4'b0000 JC: pc_load=c_flag, else pc_inc=1.
  - 4'b0001 JNC: pc_load=~c_flag, else pc_inc=1.
  - An untaken jump skips its address byte via pc_inc.
  - 4'b1111 HALT: no strobes; next state HALTED.
  - All other opcodes: exec_strobe=1, no PC strobe.
  - Next state FETCH, except HALT.
- pc_target = {oprnd, program_byte}. It is combinational and valid whenever pc_load=1; otherwise don't-care, held at that value.
- pc_load and pc_inc are never both 1.
- Flags are sampled combinationally in the EXEC cycle.
- retired increments by 1 on every EXEC cycle with hold=0, including HALT. Wraps 2^CNT_W-1 -> 0.
- HALTED: resume=1 -> FETCH; PC already points past the HALT byte.
- hold=1 in any state: state and retired unchanged, strobes 0. Releasing hold resumes the same state, with no lost or duplicated strobe.
- reset=1 has priority over start/resume/hold in the same cycle.
- reset mid-EXEC: no strobe is issued that cycle; state -> IDLE next edge.
- PC wrap 0xFFF -> 0x000 belongs to the PC. A jump opcode at 0xFFF takes its address byte from 0x000.

Test Plan:
- Reset, then start with a ROM of non-jump opcodes (0x42, 0x53) -> fetch_en/pc_inc pulse on alternate cycles, exec_strobe in each EXEC, retired=2 after 4 cycles.
- JMP 0xB3 followed by byte 0x7A -> EXEC: pc_load=1, pc_target=0x37A, pc_inc=0; next fetch from 0x37A.
- JZ (0x8_) with z_flag=0 -> pc_inc=1, pc_load=0, PC skips the address byte. Repeat with z_flag=1 -> pc_load=1. Repeat JNC with c_flag=1 -> skip.
- HALT 0xF0 -> halted=1 and no strobes for 10 cycles; resume pulse -> FETCH at HALT address+1, retired counts the HALT.
- hold=1 asserted in FETCH for 3 cycles -> no strobes, state frozen; release -> exactly one fetch_en pulse.
- reset asserted during EXEC of a taken JMP -> pc_load=0 that cycle, IDLE next, retired=0. Separately, preload retired near 0xFFFF via a run of 65536 non-jump instructions -> wraps to 0.
